pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: REG_AW, 4, register address width.
REQ-002 SHALL have parameter: MULT_LAT, 3, multiplier occupancy of EX in cycles (>=1).
REQ-003 SHALL have parameter: CNT_W, 16, stall counter width.
REQ-004 SHALL have port: CLK  in  1  clock; all state updates on posedge.
REQ-005 SHALL have port: RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: id_valid  in  1  decode holds a valid instruction.
REQ-007 SHALL have ports: id_rs_a, id_rs_b  in  REG_AW  decode source registers.
REQ-008 SHALL have ports: id_use_a, id_use_b  in  1  source actually read.
REQ-009 SHALL have port: id_is_mult  in  1  decode instruction is multiply.
REQ-010 SHALL have ports: ex_rd  in  REG_AW, ex_wb  in  1  EX destination / write enable.
REQ-011 SHALL have ports: wb_rd  in  REG_AW, wb_wb  in  1  WB destination / write enable.
REQ-012 SHALL have port: ex_branch_taken  in  1  jump/branch resolved taken in EX.
REQ-013 SHALL have ports: fwd_a, fwd_b  out  2  operand select: 0 regbank, 1 EX result, 2 WB result.
REQ-014 SHALL have ports: pc_we  out  1; id_ex_we  out  1; id_ex_bubble  out  1 (load NOP into Dec/Exe); if_id_flush  out  1.
REQ-015 SHALL have ports: state  out  2 (RUN=0, MULT=1, FLUSH=2); stall_cycles  out  CNT_W.

Function
REQ-016 SHALL implement FSM RUN/MULT/FLUSH plus down-counter mcnt of width clog2(MULT_LAT)+1.
REQ-017 RUN, no event: pc_we=1, id_ex_we=1, bubble=0, flush=0.
REQ-018 RUN and ex_branch_taken: pc_we=1, flush=1, bubble=1; next FLUSH (covers 1-cycle instruction memory latency).
REQ-019 FLUSH: pc_we=1, id_ex_we=1, bubble=1, flush=0; next RUN unconditionally.
REQ-020 RUN, id_valid & id_is_mult & MULT_LAT>1, no branch: normal issue this cycle; next MULT, mcnt=MULT_LAT-2.
REQ-021 MULT: pc_we=0, id_ex_we=0 (hold); mcnt decrements; at mcnt==0 next RUN.
REQ-022 Branch and mult-issue same cycle: branch wins, mult is flushed, no MULT entry.
REQ-023 ex_branch_taken SHALL be ignored in MULT and FLUSH.
REQ-024 Register address 0 SHALL never match for forwarding or hazard.
REQ-025 Forward select per operand: EX match (ex_wb, ex_rd==rs, use) over WB match; else 0; fwd forced 0 when use bit low.
REQ-026 stall_cycles SHALL increment each non-reset cycle with pc_we=0, saturating at all-ones.
REQ-027 All control outputs SHALL be combinational from state and inputs; no additional latency.

Reset
REQ-028 While RST=1: state RUN, mcnt 0, stall_cycles 0, pc_we=0, id_ex_we=1, bubble=1, flush=1, fwd_a=fwd_b=0.
REQ-029 RST asserted mid-MULT or mid-FLUSH SHALL abort to RUN on the next edge.

Configuration
REQ-030 Macro HAZ_FWD_EN defined: forwarding per REQ-025, no RAW stalls.
REQ-031 Macro HAZ_FWD_EN undefined: fwd_a=fwd_b=0 always; in RUN any REQ-025 match with id_valid SHALL give pc_we=0, id_ex_we=1, bubble=1 (counted by stall_cycles), branch still has priority.

Structure
REQ-032 Shared package pipe_pkg SHALL hold state encoding and FWD_REG/FWD_EX/FWD_WB constants.
REQ-033 Sub-module hazard_match (combinational source/dest compare, one per operand) SHALL be instantiated twice.

Verification
REQ-034 Reset then idle: state=0, pc_we=1, stall_cycles=0 after RST release.
REQ-035 id_rs_a=3, ex_rd=3, ex_wb=1, wb_rd=3, wb_wb=1 -> fwd_a=1 (EN) / stall one cycle, stall_cycles=1 (no EN).
REQ-036 id_is_mult with MULT_LAT=3 -> MULT for 2 cycles, pc_we=0 twice, stall_cycles=2.
REQ-037 ex_branch_taken=1 in RUN -> flush=1,bubble=1, then FLUSH cycle bubble=1, then RUN.
REQ-038 Branch and mult same cycle -> FLUSH, never MULT; rs_a=0 with ex_rd=0 -> fwd_a=0.
REQ-039 CNT_W=4, forced 20 stall cycles -> stall_cycles holds 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : shared state encoding and operand-select constants         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl_if : pipeline-side decode/EX/WB view and controls    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_a;
  logic [REG_AW-1:0] id_rs_b;
  logic              id_use_a;
  logic              id_use_b;
  logic              id_is_mult;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wb;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_wb;
  logic              ex_branch_taken;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              pc_we;
  logic              id_ex_we;
  logic              id_ex_bubble;
  logic              if_id_flush;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_is_mult,
           ex_rd, ex_wb, wb_rd, wb_wb, ex_branch_taken,
    input  fwd_a, fwd_b, pc_we, id_ex_we, id_ex_bubble, if_id_flush,
           state, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_is_mult,
           ex_rd, ex_wb, wb_rd, wb_wb, ex_branch_taken,
    output fwd_a, fwd_b, pc_we, id_ex_we, id_ex_bubble, if_id_flush,
           state, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_match : one source operand against EX/WB destinations          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  wire logic [REG_AW-1:0] i_rs,
  input  wire logic              i_use,
  input  wire logic [REG_AW-1:0] i_exRd,
  input  wire logic              i_exWb,
  input  wire logic [REG_AW-1:0] i_wbRd,
  input  wire logic              i_wbWb,
  output logic      [1:0]        o_fwdSel
);
  logic w_exHit;
  logic w_wbHit;

  // r0 is hardwired zero, so it can never carry a dependency
  assign w_exHit = i_use && (i_rs != '0) && i_exWb && (i_exRd == i_rs);
  assign w_wbHit = i_use && (i_rs != '0) && i_wbWb && (i_wbRd == i_rs);

  assign o_fwdSel = w_exHit ? FWD_EX : (w_wbHit ? FWD_WB : FWD_REG);
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl : RUN/MULT/FLUSH stall, flush and forward control    |
// | HAZ_FWD_EN defined: forwarding; undefined: RAW interlock stalls       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int MULT_LAT = 3,
  parameter int CNT_W    = 16
) (
  input wire logic          CLK,
  input wire logic          RST,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int                  c_MCNT_W     = $clog2(MULT_LAT) + 1;
  localparam bit                  c_MULT_MULTI = (MULT_LAT > 1);
  localparam logic [c_MCNT_W-1:0] c_MCNT_INIT  = c_MCNT_W'((MULT_LAT > 1) ? MULT_LAT - 2 : 0);

  state_t              r_state;
  state_t              w_stateNext;
  logic [c_MCNT_W-1:0] r_mcnt;
  logic [c_MCNT_W-1:0] w_mcntNext;
  logic [CNT_W-1:0]    r_stallCnt;
  logic [1:0]          w_selA;
  logic [1:0]          w_selB;
  logic                w_rawStall;
  logic                w_pcWe;
  logic                w_idExWe;
  logic                w_bubble;
  logic                w_flush;

  hazard_match #(.REG_AW(REG_AW)) u_matchA (
    .i_rs    (bus.id_rs_a),
    .i_use   (bus.id_use_a),
    .i_exRd  (bus.ex_rd),
    .i_exWb  (bus.ex_wb),
    .i_wbRd  (bus.wb_rd),
    .i_wbWb  (bus.wb_wb),
    .o_fwdSel(w_selA)
  );

  hazard_match #(.REG_AW(REG_AW)) u_matchB (
    .i_rs    (bus.id_rs_b),
    .i_use   (bus.id_use_b),
    .i_exRd  (bus.ex_rd),
    .i_exWb  (bus.ex_wb),
    .i_wbRd  (bus.wb_rd),
    .i_wbWb  (bus.wb_wb),
    .o_fwdSel(w_selB)
  );

`ifdef HAZ_FWD_EN
  assign w_rawStall = 1'b0;
  assign bus.fwd_a  = RST ? FWD_REG : w_selA;
  assign bus.fwd_b  = RST ? FWD_REG : w_selB;
`else
  // Without bypass paths any producer still in flight forces an interlock
  assign w_rawStall = bus.id_valid && ((w_selA != FWD_REG) || (w_selB != FWD_REG));
  assign bus.fwd_a  = FWD_REG;
  assign bus.fwd_b  = FWD_REG;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
      r_mcnt  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_mcnt  <= w_mcntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_mcntNext  = r_mcnt;
    w_pcWe      = 1'b1;
    w_idExWe    = 1'b1;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.ex_branch_taken) begin
          // Second bubble cycle covers the instruction memory latency
          w_bubble    = 1'b1;
          w_flush     = 1'b1;
          w_stateNext = FLUSH;
        end else if (w_rawStall) begin
          w_pcWe   = 1'b0;
          w_bubble = 1'b1;
        end else if (bus.id_valid && bus.id_is_mult && c_MULT_MULTI) begin
          w_stateNext = MULT;
          w_mcntNext  = c_MCNT_INIT;
        end
      end
      MULT: begin
        w_pcWe   = 1'b0;
        w_idExWe = 1'b0;
        if (r_mcnt == '0) begin
          w_stateNext = RUN;
        end else begin
          w_mcntNext = r_mcnt - c_MCNT_W'(1);
        end
      end
      FLUSH: begin
        w_bubble    = 1'b1;
        w_stateNext = RUN;
      end
      default: begin
        w_stateNext = RUN;
      end
    endcase
    if (RST) begin
      w_pcWe   = 1'b0;
      w_idExWe = 1'b1;
      w_bubble = 1'b1;
      w_flush  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stallCnt <= '0;
    end else if (!w_pcWe && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

  assign bus.pc_we        = w_pcWe;
  assign bus.id_ex_we     = w_idExWe;
  assign bus.id_ex_bubble = w_bubble;
  assign bus.if_id_flush  = w_flush;
  assign bus.state        = RST ? RUN : r_state;
  assign bus.stall_cycles = RST ? '0 : r_stallCnt;
endmodule
`default_nettype wire
